// File: rtl/dds_cmd_writer.sv
// rtl/dds_cmd_writer.sv - framed UART command parser committing DDS Fword/Pword/Mode_Sel
`timescale 1ns/1ps
module dds_cmd_writer #(
    parameter int         TIMEOUT_CYC = 1_000_000,
    parameter logic [7:0] ACK_BYTE    = 8'h06,
    parameter logic [7:0] NAK_BYTE    = 8'h15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  Rx_Data,
    input  logic        Rx_Done,
    output logic [7:0]  Tx_Data,
    output logic        Tx_Valid,
    input  logic        Tx_Ready,
    output logic [31:0] Fword,
    output logic [11:0] Pword,
    output logic [1:0]  Mode_Sel,
    output logic        Param_Update,
    output logic [7:0]  Err_Cnt
);
    localparam int            TW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_PAYLOAD, S_CHECK, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [1:0]    cmd_q;
    logic [2:0]    cnt_q;
    logic [31:0]   shadow_q;
    logic [7:0]    xor_q;
    logic          chk_pend_q;
    logic [7:0]    chk_byte_q;
    logic [TW-1:0] tcnt_q;

    logic          in_frame, timeout, cmd_ok, err_inc;

    assign in_frame = (state_q == S_CMD) || (state_q == S_PAYLOAD) || (state_q == S_CHECK);
    // A byte landing on the expiry cycle always wins over the timeout.
    assign timeout  = in_frame && !Rx_Done && !chk_pend_q && (tcnt_q == TLIM);
    assign cmd_ok   = (Rx_Data == 8'h01) || (Rx_Data == 8'h02) || (Rx_Data == 8'h03);

    always_ff @(posedge Clk) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_inc = 1'b0;
        case (state_q)
            S_IDLE:    if (Rx_Done && Rx_Data == 8'hA5) state_d = S_CMD;
            S_CMD: begin
                if (timeout) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end else if (Rx_Done) begin
                    state_d = cmd_ok ? S_PAYLOAD : S_RESP;
                    err_inc = !cmd_ok;
                end
            end
            S_PAYLOAD: begin
                if (timeout) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end else if (Rx_Done && cnt_q == 3'd1) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (chk_pend_q) begin
                    state_d = S_RESP;
                    err_inc = (chk_byte_q != xor_q);
                end else if (timeout) begin
                    state_d = S_IDLE;
                    err_inc = 1'b1;
                end
            end
            S_RESP:    if (Tx_Ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            Fword        <= '0;
            Pword        <= '0;
            Mode_Sel     <= '0;
            Tx_Data      <= '0;
            Tx_Valid     <= 1'b0;
            Param_Update <= 1'b0;
            Err_Cnt      <= '0;
            cmd_q        <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            xor_q        <= '0;
            chk_pend_q   <= 1'b0;
            chk_byte_q   <= '0;
            tcnt_q       <= '0;
        end else begin
            Param_Update <= 1'b0;
            if (err_inc && Err_Cnt != 8'hFF) Err_Cnt <= Err_Cnt + 8'd1;

            if (in_frame && !Rx_Done && !timeout) tcnt_q <= tcnt_q + 1'b1;
            else                                  tcnt_q <= '0;

            case (state_q)
                S_CMD: if (!timeout && Rx_Done) begin
                    if (cmd_ok) begin
                        cmd_q    <= Rx_Data[1:0];
                        cnt_q    <= (Rx_Data[1:0] == 2'd1) ? 3'd4 :
                                    (Rx_Data[1:0] == 2'd2) ? 3'd2 : 3'd1;
                        xor_q    <= Rx_Data;
                        shadow_q <= '0;
                    end else begin
                        Tx_Data  <= NAK_BYTE;
                        Tx_Valid <= 1'b1;
                    end
                end
                S_PAYLOAD: if (!timeout && Rx_Done) begin
                    shadow_q <= {shadow_q[23:0], Rx_Data};
                    xor_q    <= xor_q ^ Rx_Data;
                    cnt_q    <= cnt_q - 3'd1;
                end
                S_CHECK: begin
                    // The checksum byte is registered first so commit lands one edge after it.
                    if (chk_pend_q) begin
                        chk_pend_q <= 1'b0;
                        Tx_Valid   <= 1'b1;
                        if (chk_byte_q == xor_q) begin
                            Tx_Data      <= ACK_BYTE;
                            Param_Update <= 1'b1;
                            case (cmd_q)
                                2'd1:    Fword    <= shadow_q;
                                2'd2:    Pword    <= shadow_q[11:0];
                                default: Mode_Sel <= shadow_q[1:0];
                            endcase
                        end else begin
                            Tx_Data <= NAK_BYTE;
                        end
                    end else if (Rx_Done) begin
                        chk_pend_q <= 1'b1;
                        chk_byte_q <= Rx_Data;
                    end
                end
                S_RESP: if (Tx_Ready) Tx_Valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_cmd_writer.sv
// tb/tb_dds_cmd_writer.sv - scoreboard bench for dds_cmd_writer
`timescale 1ns/1ps
module tb_dds_cmd_writer;
    localparam int         T   = 40;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [7:0]  Rx_Data = 8'h00;
    logic        Rx_Done = 1'b0;
    logic        Tx_Ready = 1'b1;
    logic [7:0]  Tx_Data;
    logic        Tx_Valid;
    logic [31:0] Fword;
    logic [11:0] Pword;
    logic [1:0]  Mode_Sel;
    logic        Param_Update;
    logic [7:0]  Err_Cnt;

    dds_cmd_writer #(.TIMEOUT_CYC(T)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Rx_Data(Rx_Data), .Rx_Done(Rx_Done),
        .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Ready(Tx_Ready),
        .Fword(Fword), .Pword(Pword), .Mode_Sel(Mode_Sel),
        .Param_Update(Param_Update), .Err_Cnt(Err_Cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [7:0]  tx;
        logic [31:0] f;
        logic [11:0] p;
        logic [1:0]  m;
        logic [7:0]  e;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] mf = '0;
    logic [11:0] mp = '0;
    logic [1:0]  mm = '0;
    logic [7:0]  me = '0;
    int          acks = 0;
    int          pu_cnt = 0;
    logic        pu_prev = 1'b0;
    logic        hold_prev = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        Rx_Data = b;
        Rx_Done = 1'b1;
        tick();
        Rx_Done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic push_ack();
        acks++;
        sb.push_back({ACK, mf, mp, mm, me});
    endtask

    task automatic push_nak();
        if (me != 8'hFF) me = me + 8'd1;
        sb.push_back({NAK, mf, mp, mm, me});
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fword"}, Fword, 0);
        check({tag, "_pword"}, {20'd0, Pword}, 0);
        check({tag, "_mode"}, {30'd0, Mode_Sel}, 0);
        check({tag, "_txdata"}, {24'd0, Tx_Data}, 0);
        check({tag, "_txvalid"}, {31'd0, Tx_Valid}, 0);
        check({tag, "_pupd"}, {31'd0, Param_Update}, 0);
        check({tag, "_errcnt"}, {24'd0, Err_Cnt}, 0);
    endtask

    // Monitor: pops the scoreboard on every accepted response, watches hold stability and pulses.
    always @(negedge Clk) begin
        if (Reset_n) begin
            if (Tx_Valid && Tx_Ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got %0h, expected no response", Tx_Data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("resp_byte", {24'd0, Tx_Data}, {24'd0, e.tx});
                    check("resp_fword", Fword, e.f);
                    check("resp_pword", {20'd0, Pword}, {20'd0, e.p});
                    check("resp_mode", {30'd0, Mode_Sel}, {30'd0, e.m});
                    check("resp_errcnt", {24'd0, Err_Cnt}, {24'd0, e.e});
                end
            end
            if (hold_prev) begin
                check("hold_valid", {31'd0, Tx_Valid}, 1);
                check("hold_data", {24'd0, Tx_Data}, {24'd0, prev_data});
            end
            if (Param_Update) begin
                pu_cnt++;
                check("pupd_width", {31'd0, pu_prev}, 0);
                check("pupd_with_ack", {23'd0, Tx_Valid, Tx_Data}, {23'd0, 1'b1, ACK});
            end
        end
        hold_prev = Reset_n && Tx_Valid && !Tx_Ready;
        prev_data = Tx_Data;
        pu_prev   = Param_Update;
    end

    initial begin
        idle(3);
        check_all_zero("reset");
        Reset_n = 1'b1;
        idle(2);

        // Fword commit
        send(8'hA5); send(8'h01); send(8'h00); send(8'h10); send(8'h00); send(8'h00);
        mf = 32'h0010_0000; push_ack();
        send(8'h11); idle(4);

        // Pword commit with upper nibble ignored, bad-checksum mode, mode 3 accepted
        send(8'hA5); send(8'h02); send(8'hF8); send(8'h00);
        mp = 12'h800; push_ack();
        send(8'hFA); idle(4);
        send(8'hA5); send(8'h03); send(8'h02);
        push_nak();
        send(8'h00); idle(4);
        check("mode_after_nak", {30'd0, Mode_Sel}, 0);
        check("err_after_bad_chk", {24'd0, Err_Cnt}, 1);
        send(8'hA5); send(8'h03); send(8'h03);
        mm = 2'd3; push_ack();
        send(8'h00); idle(4);

        // Unknown command then a good frame
        send(8'hA5);
        push_nak();
        send(8'h07); idle(4);
        send(8'hA5); send(8'h02); send(8'h01); send(8'h23);
        mp = 12'h123; push_ack();
        send(8'h20); idle(4);

        // Timeout, then a byte arriving exactly on the expiry cycle
        send(8'hA5); send(8'h01); send(8'h00);
        idle(T + 5);
        if (me != 8'hFF) me = me + 8'd1;
        check("err_after_timeout", {24'd0, Err_Cnt}, {24'd0, me});
        check("txvalid_after_timeout", {31'd0, Tx_Valid}, 0);
        send(8'hA5); send(8'h01); send(8'h00);
        idle(T - 1);
        send(8'h00); send(8'h12); send(8'h34);
        mf = 32'h0000_1234; push_ack();
        send(8'h27); idle(4);
        check("err_no_timeout_on_expiry", {24'd0, Err_Cnt}, {24'd0, me});

        // Backpressure: response held while bytes arrive and are dropped
        send(8'hA5); send(8'h01); send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
        mf = 32'hDEAD_BEEF; push_ack();
        Tx_Ready = 1'b0;
        send(8'h23); idle(3);
        send(8'hA5); send(8'h02); send(8'h00); send(8'h01); send(8'h03);
        idle(42);
        check("pword_unchanged_in_resp", {20'd0, Pword}, {20'd0, mp});
        Tx_Ready = 1'b1;
        idle(4);

        // Reset mid-payload, then recovery and saturation
        send(8'hA5); send(8'h01); send(8'hAA); send(8'hBB);
        Reset_n = 1'b0;
        idle(2);
        check_all_zero("midreset");
        mf = '0; mp = '0; mm = '0; me = '0;
        Reset_n = 1'b1;
        tick();
        send(8'hA5); send(8'h03); send(8'h01);
        mm = 2'd1; push_ack();
        send(8'h02); idle(4);
        for (int i = 0; i < 256; i++) begin
            send(8'hA5);
            push_nak();
            send(8'h07);
            idle(2);
        end
        check("err_saturated", {24'd0, Err_Cnt}, 32'hFF);

        idle(5);
        check("scoreboard_drained", sb.size(), 0);
        check("pupd_count", pu_cnt, acks);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
